// File: rtl/compressor_top.sv
// ============================================================================
// Module      : compressor_top
// Description : Whole-image one-level 2D Haar transform with per-subband
//               arithmetic-shift quantization and saturation. One band of
//               BAND_ROWS rows is transformed and registered per clock.
//               Optional feature macro: ROUND_EN (round half up before the
//               shift instead of a plain floor shift).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module compressor_top #(
    parameter int IMG_H     = 480,
    parameter int IMG_W     = 640,
    parameter int BAND_ROWS = 8,
    parameter int DW        = 9,
    parameter int Q_LL      = 2,
    parameter int Q_H       = 3,
    parameter int Q_HH      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,      // active-high synchronous reset
    input  logic                 start_img,
    input  logic signed [DW-1:0] image                [IMG_H][IMG_W],
    output logic signed [DW-1:0] quantized_coeffs_out [IMG_H][IMG_W],
    output logic                 img_done
);

    localparam int c_NBANDS = IMG_H / BAND_ROWS;
    localparam int c_BW     = (c_NBANDS > 1) ? $clog2(c_NBANDS) : 1;
    localparam int c_RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic signed [DW+3:0] c_SAT_HI = $signed((DW+4)'((1 << (DW-1)) - 1));
    localparam logic signed [DW+3:0] c_SAT_LO = -$signed((DW+4)'(1 << (DW-1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_BW-1:0]   band_q, band_d;
    logic              img_done_q, img_done_d;
    logic [c_RW-1:0]   w_row_base;

    logic signed [DW-1:0] coeffs_q [IMG_H][IMG_W];
    logic signed [DW-1:0] w_band   [BAND_ROWS][IMG_W];

    // Shift (optionally rounding first) and clamp to the DW-bit signed range.
    // One guard bit above the DW+3 sum keeps the rounding add from wrapping.
    function automatic logic signed [DW-1:0] f_quant(input logic signed [DW+2:0] v,
                                                     input int sh);
        logic signed [DW+3:0] t;
        t = (DW+4)'(v);
`ifdef ROUND_EN
        if (sh > 0) begin
            t = t + ($signed((DW+4)'(1)) <<< (sh - 1));
        end
`endif
        t = t >>> sh;
        if (t > c_SAT_HI) begin
            t = c_SAT_HI;
        end else if (t < c_SAT_LO) begin
            t = c_SAT_LO;
        end
        return t[DW-1:0];
    endfunction

    // First row of the band currently being transformed.
    assign w_row_base = c_RW'(band_q) * c_RW'(BAND_ROWS);

    // Combinational band datapath: one Haar butterfly per 2x2 block.
    genvar gi, gj;
    generate
        for (gi = 0; gi < BAND_ROWS / 2; gi++) begin : g_blk_row
            logic [c_RW-1:0] w_r0, w_r1;
            assign w_r0 = w_row_base + c_RW'(2 * gi);
            assign w_r1 = w_row_base + c_RW'(2 * gi + 1);
            for (gj = 0; gj < IMG_W / 2; gj++) begin : g_blk_col
                logic signed [DW+2:0] w_a, w_b, w_c, w_d;
                logic signed [DW+2:0] w_ll, w_hl, w_lh, w_hh;
                assign w_a  = (DW+3)'(image[w_r0][2*gj]);
                assign w_b  = (DW+3)'(image[w_r0][2*gj+1]);
                assign w_c  = (DW+3)'(image[w_r1][2*gj]);
                assign w_d  = (DW+3)'(image[w_r1][2*gj+1]);
                assign w_ll = w_a + w_b + w_c + w_d;
                assign w_hl = w_a - w_b + w_c - w_d;
                assign w_lh = w_a + w_b - w_c - w_d;
                assign w_hh = w_a - w_b - w_c + w_d;
                assign w_band[2*gi][2*gj]     = f_quant(w_ll, Q_LL);
                assign w_band[2*gi][2*gj+1]   = f_quant(w_hl, Q_H);
                assign w_band[2*gi+1][2*gj]   = f_quant(w_lh, Q_H);
                assign w_band[2*gi+1][2*gj+1] = f_quant(w_hh, Q_HH);
            end
        end
    endgenerate

    // Control state register; reset aborts any image in flight.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            band_q     <= '0;
            img_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            band_q     <= band_d;
            img_done_q <= img_done_d;
        end
    end

    // Next-state logic: start is only honoured outside RUN; done is a level
    // that appears one cycle after the last band has been written.
    always_comb begin
        state_d    = state_q;
        band_d     = band_q;
        img_done_d = img_done_q;
        case (state_q)
            IDLE: begin
                if (start_img) begin
                    state_d    = RUN;
                    band_d     = '0;
                    img_done_d = 1'b0;
                end
            end
            RUN: begin
                if (band_q == c_BW'(c_NBANDS - 1)) begin
                    state_d = DONE;
                end else begin
                    band_d = band_q + 1'b1;
                end
            end
            DONE: begin
                img_done_d = 1'b1;
                if (start_img) begin
                    state_d    = RUN;
                    band_d     = '0;
                    img_done_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output array: only the current band's rows are rewritten each RUN cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            coeffs_q <= '{default: '0};
        end else if (state_q == RUN) begin
            for (int r = 0; r < BAND_ROWS; r++) begin
                coeffs_q[w_row_base + c_RW'(r)] <= w_band[r];
            end
        end
    end

    assign quantized_coeffs_out = coeffs_q;
    assign img_done             = img_done_q;

endmodule

`default_nettype wire

// File: tb/tb_compressor_top.sv
// ============================================================================
// Module      : tb_compressor_top
// Description : Randomized self-checking bench for compressor_top with a
//               whole-image behavioural Haar/quantizer model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compressor_top;

    localparam int H   = 480;
    localparam int W   = 640;
    localparam int BR  = 8;
    localparam int QLL = 2;
    localparam int QH  = 3;
    localparam int QHH = 4;
    localparam int LAT = H / BR + 1;

`ifdef ROUND_EN
    localparam int BLK_HH = 64;
    localparam int BLK_LL = 0;
`else
    localparam int BLK_HH = 63;
    localparam int BLK_LL = -1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic start_img;
    logic img_done;
    logic signed [8:0] img    [H][W];
    logic signed [8:0] coeffs [H][W];

    logic sat_start;
    logic sat_done;
    logic signed [8:0] sat_img [4][4];
    logic signed [8:0] sat_out [4][4];

    int exp_new [H][W];
    int exp_old [H][W];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    compressor_top u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_img            (start_img),
        .image                (img),
        .quantized_coeffs_out (coeffs),
        .img_done             (img_done)
    );

    compressor_top #(
        .IMG_H(4), .IMG_W(4), .BAND_ROWS(2), .DW(9), .Q_LL(0), .Q_H(3), .Q_HH(4)
    ) u_sat (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_img            (sat_start),
        .image                (sat_img),
        .quantized_coeffs_out (sat_out),
        .img_done             (sat_done)
    );

    task automatic check_val(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Floor (or round-half-up) division by 2^sh, then clamp to 9-bit signed.
    function automatic int m_quant(input int v, input int sh);
        int d, n, q;
        d = 1 << sh;
        n = v;
`ifdef ROUND_EN
        if (sh > 0) n = n + d / 2;
`endif
        q = (n >= 0) ? n / d : -((-n + d - 1) / d);
        if (q > 255)  q = 255;
        if (q < -256) q = -256;
        return q;
    endfunction

    task automatic build_exp();
        int a, b, c, d;
        for (int i = 0; i < H / 2; i++) begin
            for (int j = 0; j < W / 2; j++) begin
                a = img[2*i][2*j];
                b = img[2*i][2*j+1];
                c = img[2*i+1][2*j];
                d = img[2*i+1][2*j+1];
                exp_new[2*i][2*j]     = m_quant(a + b + c + d, QLL);
                exp_new[2*i][2*j+1]   = m_quant(a - b + c - d, QH);
                exp_new[2*i+1][2*j]   = m_quant(a + b - c - d, QH);
                exp_new[2*i+1][2*j+1] = m_quant(a - b - c + d, QHH);
            end
        end
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 9'(v);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 9'($urandom_range(511, 0));
    endtask

    task automatic zero_old();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_old[r][c] = 0;
    endtask

    // Rows below new_rows must hold the new image's result, the rest the old one.
    task automatic cmp_all(input string tag, input int new_rows);
        int bad, fr, fc, e;
        bad = 0; fr = 0; fc = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                e = (r < new_rows) ? exp_new[r][c] : exp_old[r][c];
                if (int'(coeffs[r][c]) != e) begin
                    if (bad == 0) begin fr = r; fc = c; end
                    bad++;
                end
            end
        end
        check_val({tag, "_nbad"}, bad, 0);
        if (bad > 0)
            check_val($sformatf("%s_first_r%0d_c%0d", tag, fr, fc), int'(coeffs[fr][fc]),
                      (fr < new_rows) ? exp_new[fr][fc] : exp_old[fr][fc]);
    endtask

    task automatic run_image(input string tag, input int extra_start_at, input int mid_at);
        int lat;
        start_img = 1'b1;
        @(posedge clk); #1;
        start_img = 1'b0;
        check_val({tag, "_done_low"}, int'(img_done), 0);
        lat = 0;
        while (img_done !== 1'b1 && lat < 200) begin
            start_img = (lat == extra_start_at);
            @(posedge clk); #1;
            lat++;
            start_img = 1'b0;
            if (lat == mid_at) cmp_all({tag, "_mid"}, mid_at * BR);
        end
        check_val({tag, "_latency"}, lat, LAT);
        cmp_all(tag, H);
        exp_old = exp_new;
    endtask

    task automatic sat_run(input string tag, input int pix, input int ll_exp);
        int lat;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                sat_img[r][c] = 9'(pix);
        sat_start = 1'b1;
        @(posedge clk); #1;
        sat_start = 1'b0;
        lat = 0;
        while (sat_done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_latency"}, lat, 3);
        check_val({tag, "_ll00"}, int'(sat_out[0][0]), ll_exp);
        check_val({tag, "_ll22"}, int'(sat_out[2][2]), ll_exp);
        check_val({tag, "_hl01"}, int'(sat_out[0][1]), 0);
        check_val({tag, "_lh30"}, int'(sat_out[3][0]), 0);
        check_val({tag, "_hh33"}, int'(sat_out[3][3]), 0);
    endtask

    initial begin
        rst_n     = 1'b1;
        start_img = 1'b0;
        sat_start = 1'b0;
        fill_const(0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                sat_img[r][c] = '0;
        zero_old();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_done", int'(img_done), 0);
        check_val("rst_sat_done", int'(sat_done), 0);
        cmp_all("rst", 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("idle_done", int'(img_done), 0);

        // Constant image: only LL carries energy.
        fill_const(100);
        build_exp();
        run_image("const", -1, -1);
        check_val("const_ll", int'(coeffs[0][0]), 100);
        check_val("const_hl", int'(coeffs[0][1]), 0);
        check_val("const_lh", int'(coeffs[1][0]), 0);
        check_val("const_hh", int'(coeffs[479][639]), 0);

        // Random image with the extreme block at both corners, a redundant
        // start mid-run and a partial-write check at band 10.
        fill_rand();
        img[0][0] = 9'h0FF;     img[0][1] = 9'h100;
        img[1][0] = 9'h100;     img[1][1] = 9'h0FF;
        img[478][638] = 9'h0FF; img[478][639] = 9'h100;
        img[479][638] = 9'h100; img[479][639] = 9'h0FF;
        build_exp();
        run_image("rand0", 15, 10);
        check_val("blk_hh", int'(coeffs[1][1]), BLK_HH);
        check_val("blk_ll", int'(coeffs[0][0]), BLK_LL);
        check_val("blk_hl", int'(coeffs[0][1]), 0);
        check_val("blk_lh", int'(coeffs[1][0]), 0);
        check_val("blk_hh_last", int'(coeffs[479][639]), BLK_HH);
        repeat (3) @(posedge clk);
        #1;
        check_val("done_held", int'(img_done), 1);

        // Restarts from DONE with fresh random images.
        for (int k = 1; k <= 2; k++) begin
            fill_rand();
            build_exp();
            run_image($sformatf("rand%0d", k), -1, 7 * k);
        end

        // Abort with reset while band 20 is pending, then a clean rerun.
        fill_rand();
        build_exp();
        start_img = 1'b1;
        @(posedge clk); #1;
        start_img = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        check_val("abort_done", int'(img_done), 0);
        zero_old();
        cmp_all("abort", 0);
        run_image("after_abort", -1, -1);

        // LL saturation with a zero shift on a small instance.
        sat_run("sat_pos", 255, 255);
        sat_run("sat_neg", -256, -256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
